// File: rtl/tdm_pkg.sv
// Shared types and constants for the two-channel TDM demultiplexer.
// TDM_DEMUX_PARITY_EN adds a third (parity) slot per frame and the EXPP state.
package tdm_pkg;

  localparam int FRAME_CNT_W = 16;

  localparam int SLOT_DATA0  = 0;
  localparam int SLOT_DATA1  = 1;
  localparam int SLOT_PARITY = 2;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int SLOTS_PER_FRAME = 3;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EXP1 = 2'd1,
    EXP0 = 2'd2,
    EXPP = 2'd3
  } state_t;
`else
  localparam int SLOTS_PER_FRAME = 2;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    EXP1 = 2'd1,
    EXP0 = 2'd2
  } state_t;
`endif

endpackage

// File: rtl/tdm_frame_fsm.sv
// Frame-alignment FSM: tracks slot position and emits capture/deliver/error strobes.
// With TDM_DEMUX_PARITY_EN a parity slot is checked in the EXPP state.
module tdm_frame_fsm
  import tdm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din_valid,
  input  logic sync,
`ifdef TDM_DEMUX_PARITY_EN
  input  logic parity_ok,
  output logic cap1,
  output logic parity_error,
`endif
  output logic cap0,
  output logic deliver,
  output logic sync_error
);

  state_t state_reg;
  state_t state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= HUNT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (din_valid) begin
      case (state_reg)
        HUNT: begin
          if (sync) state_next = EXP1;
        end
        EXP1: begin
`ifdef TDM_DEMUX_PARITY_EN
          if (!sync) state_next = EXPP;
`else
          if (!sync) state_next = EXP0;
`endif
        end
        EXP0: begin
          state_next = sync ? EXP1 : HUNT;
        end
`ifdef TDM_DEMUX_PARITY_EN
        EXPP: begin
          state_next = sync ? EXP1 : EXP0;
        end
`endif
        default: state_next = HUNT;
      endcase
    end
  end

  // A sync seen mid-frame restarts the frame on that beat rather than hunting again.
  always_comb begin
    cap0       = 1'b0;
    deliver    = 1'b0;
    sync_error = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
    cap1         = 1'b0;
    parity_error = 1'b0;
`endif
    if (din_valid) begin
      case (state_reg)
        HUNT: begin
          cap0 = sync;
        end
        EXP1: begin
          if (sync) begin
            sync_error = 1'b1;
            cap0       = 1'b1;
          end else begin
`ifdef TDM_DEMUX_PARITY_EN
            cap1 = 1'b1;
`else
            deliver = 1'b1;
`endif
          end
        end
        EXP0: begin
          if (sync) begin
            cap0 = 1'b1;
          end else begin
            sync_error = 1'b1;
          end
        end
`ifdef TDM_DEMUX_PARITY_EN
        EXPP: begin
          if (sync) begin
            sync_error = 1'b1;
            cap0       = 1'b1;
          end else if (parity_ok) begin
            deliver = 1'b1;
          end else begin
            parity_error = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tdm_demux2.sv
// Two-channel TDM demultiplexer: splits sync-framed slot words into ch0/ch1 registers.
// Define TDM_DEMUX_PARITY_EN for 3-slot frames with an XOR parity slot.
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W-1:0]           din,
  input  logic                   din_valid,
  input  logic                   sync,
  output logic [W-1:0]           ch0_data,
  output logic [W-1:0]           ch1_data,
  output logic                   out_valid,
  output logic                   sync_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   parity_err
);

  logic [W-1:0]           stage0_reg;
  logic [W-1:0]           ch0_reg;
  logic [W-1:0]           ch1_reg;
  logic                   out_valid_reg;
  logic                   sync_err_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;
  logic [W-1:0]           slot1_word;
  logic                   cap0;
  logic                   deliver;
  logic                   sync_error;

`ifdef TDM_DEMUX_PARITY_EN
  logic [W-1:0] stage1_reg;
  logic         parity_err_reg;
  logic         cap1;
  logic         parity_error;
  logic         parity_ok;

  assign parity_ok  = (din == (stage0_reg ^ stage1_reg));
  assign slot1_word = stage1_reg;
`else
  // Without parity the frame completes on the slot-1 beat itself.
  assign slot1_word = din;
`endif

  tdm_frame_fsm u_fsm (
    .clk          (clk),
    .rst          (rst),
    .din_valid    (din_valid),
    .sync         (sync),
`ifdef TDM_DEMUX_PARITY_EN
    .parity_ok    (parity_ok),
    .cap1         (cap1),
    .parity_error (parity_error),
`endif
    .cap0         (cap0),
    .deliver      (deliver),
    .sync_error   (sync_error)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage0_reg    <= '0;
      ch0_reg       <= '0;
      ch1_reg       <= '0;
      out_valid_reg <= 1'b0;
      sync_err_reg  <= 1'b0;
    end else begin
      out_valid_reg <= deliver;
      sync_err_reg  <= sync_error;
      if (cap0) begin
        stage0_reg <= din;
      end
      if (deliver) begin
        ch0_reg <= stage0_reg;
        ch1_reg <= slot1_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_reg <= '0;
    end else if (deliver) begin
      frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
    end
  end

`ifdef TDM_DEMUX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1_reg     <= '0;
      parity_err_reg <= 1'b0;
    end else begin
      parity_err_reg <= parity_error;
      if (cap1) begin
        stage1_reg <= din;
      end
    end
  end

  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  assign ch0_data  = ch0_reg;
  assign ch1_data  = ch1_reg;
  assign out_valid = out_valid_reg;
  assign sync_err  = sync_err_reg;
  assign frame_cnt = frame_cnt_reg;

  // Each accepted beat produces at most one kind of pulse.
  assert property (@(posedge clk) disable iff (rst)
    $onehot0({out_valid, sync_err, parity_err}));

endmodule
